fetch_stage: RTL and testbench

- Instruction fetch stage of the 5-stage RV32I pipeline.
- Owns the PC, issues word requests to instruction memory over a request/response handshake, and absorbs branch/jump redirects.
- Drives the IF/ID register (valid, pc, pc+4, instruction) that the decode stage and immediate generator consume.
- Guarantees at most one outstanding memory request, with a one-entry skid buffer so decode stalls never lose a returned instruction.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 50 +++++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: word width, reset/NOP constants and the
// instruction-fetch state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;
  localparam word_t NOP_INST = 32'h0000_0013;  // ADDI x0,x0,0

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    FULL,
    DISCARD
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic word_t align_pc(word_t pc);
    return pc & ~word_t'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush and bubble clear valid and force a NOP while
// keeping the pc fields; load captures a new instruction; hold freezes all.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter word_t NOP_WORD = NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              hold_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   inst_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc_plus4_o,
  output logic [XLEN-1:0]   inst_o
);

  logic  valid_q;
  word_t pc_q;
  word_t pc_plus4_q;
  word_t inst_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      inst_q     <= NOP_WORD;
    end else if (flush_i || !(load_i || hold_i)) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_WORD;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + 32'd4;
      inst_q     <= inst_i;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign inst_o     = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, keeps at most one imem request in
// flight, skids one returned word across decode stalls and absorbs redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic [31:0] id_inst_o
);

  import riscv_pkg::*;

  fetch_state_e state_q;
  word_t        pc_q;
  word_t        skid_inst_q;
  word_t        pc_plus4;
  logic         accept;

  logic         req;
  word_t        addr;
  logic         load;
  word_t        load_inst;

  assign accept   = !stall_i;
  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    req       = 1'b0;
    addr      = pc_q;
    load      = 1'b0;
    load_inst = imem_rdata_i;
    if (!redirect_i) begin
      unique case (state_q)
        FETCH: req = 1'b1;
        WAIT: begin
          if (imem_rvalid_i && accept) begin
            req  = 1'b1;
            addr = pc_plus4;
            load = 1'b1;
          end
        end
        FULL: begin
          if (accept) begin
            req       = 1'b1;
            addr      = pc_plus4;
            load      = 1'b1;
            load_inst = skid_inst_q;
          end
        end
        DISCARD: ;
      endcase
    end
  end

  assign imem_req_o  = req & rst_n;
  assign imem_addr_o = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      skid_inst_q <= NOP_INST;
    end else if (redirect_i) begin
      // An outstanding request with no response yet must be drained first.
      pc_q        <= align_pc(redirect_pc_i);
      skid_inst_q <= NOP_INST;
      state_q     <= ((state_q == WAIT || state_q == DISCARD) && !imem_rvalid_i)
                     ? DISCARD : FETCH;
    end else begin
      unique case (state_q)
        FETCH: state_q <= WAIT;
        WAIT: begin
          if (imem_rvalid_i) begin
            if (accept) begin
              pc_q <= pc_plus4;
            end else begin
              skid_inst_q <= imem_rdata_i;
              state_q     <= FULL;
            end
          end
        end
        FULL: begin
          if (accept) begin
            pc_q    <= pc_plus4;
            state_q <= WAIT;
          end
        end
        DISCARD: begin
          if (imem_rvalid_i) state_q <= FETCH;
        end
      endcase
    end
  end

  // The skid word belongs to pc_q: pc_q only advances once the word is consumed.
  if_id_reg #(
    .NOP_WORD (NOP_INST)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_i),
    .load_i     (load),
    .hold_i     (stall_i),
    .pc_i       (pc_q),
    .inst_i     (load_inst),
    .valid_o    (id_valid_o),
    .pc_o       (id_pc_o),
    .pc_plus4_o (id_pc_plus4_o),
    .inst_o     (id_inst_o)
  );

  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid_i && (state_q == FETCH || state_q == FULL)));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a memory responder, directed pipeline scenarios and a
// randomized run checked by a program-order scoreboard of expected PCs.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic [31:0] id_inst_o;

  int n_tests = 0;
  int n_fail  = 0;
  int consumed = 0;

  int mem_lat  = 1;
  bit rand_lat = 1'b0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_pc_plus4_o (id_pc_plus4_o),
    .id_inst_o     (id_inst_o)
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected program order from a new start point: sequential words, wrapping.
  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: one response per request after a 1..3 cycle latency.
  initial begin : responder
    logic        got;
    logic        pend;
    int          cnt;
    int          lat;
    logic [31:0] a;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt  = 0;
    paddr = '0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      got = imem_req_o;
      a   = imem_addr_o;
      lat = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (got) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = a;
      end
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Decode consumes IF/ID whenever it is valid, not stalled and not flushed.
  initial begin : monitor
    logic [31:0] pc;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (imem_req_o) check("addr_align", {30'b0, imem_addr_o[1:0]}, 32'h0);
        if (!id_valid_o) check("bubble_nop", id_inst_o, NOP);
        if (id_valid_o && !stall_i && !redirect_i) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got pc %h expected none", id_pc_o);
          end else begin
            pc = exp_q.pop_front();
            check("sb_pc", id_pc_o, pc);
            check("sb_pc4", id_pc_plus4_o, pc + 32'd4);
            check("sb_inst", id_inst_o, mem_word(pc));
            consumed++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] tgt;
    int          base;
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", id_valid_o, 0);
    check("rst_inst", id_inst_o, NOP);
    check("rst_pc", id_pc_o, 0);
    check("rst_pc4", id_pc_plus4_o, 0);
    check("rst_req", imem_req_o, 0);

    // c0..c2: back-to-back fetch with 1-cycle memory
    tick(); rst_n = 1'b1; restart_stream(RST_PC);
    @(negedge clk); check("c0_req", imem_req_o, 1); check("c0_addr", imem_addr_o, 32'h0);
    tick(); @(negedge clk); check("c1_addr", imem_addr_o, 32'h4);
    tick(); @(negedge clk);
    check("c2_addr", imem_addr_o, 32'h8);
    check("c2_valid", id_valid_o, 1);
    check("c2_pc", id_pc_o, 32'h0);
    check("c2_pc4", id_pc_plus4_o, 32'h4);

    // c3..c5: stall while the 0x8 response arrives
    tick(); stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", imem_req_o, 0);
      check("stall_pc", id_pc_o, 32'h4);
      if (i < 2) tick();
    end
    tick(); stall_i = 1'b0;
    @(negedge clk); check("rel_addr", imem_addr_o, 32'hC); check("rel_pc", id_pc_o, 32'h4);
    tick(); mem_lat = 2;
    @(negedge clk);
    check("skid_pc", id_pc_o, 32'h8);
    check("skid_inst", id_inst_o, mem_word(32'h8));
    check("c7_addr", imem_addr_o, 32'h10);

    // c8: redirect while 0x10 is outstanding with no response yet
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h103; restart_stream(32'h100);
    @(negedge clk); check("redir_req", imem_req_o, 0);
    tick(); redirect_i = 1'b0; mem_lat = 1;
    @(negedge clk); check("disc_valid", id_valid_o, 0); check("disc_req", imem_req_o, 0);
    tick(); @(negedge clk); check("tgt_req", imem_req_o, 1); check("tgt_addr", imem_addr_o, 32'h100);
    tick(); @(negedge clk); check("tgt_addr2", imem_addr_o, 32'h104);

    // c12: redirect together with a response and a stall
    tick(); stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200; restart_stream(32'h200);
    @(negedge clk); check("rs_req", imem_req_o, 0); check("rs_pc", id_pc_o, 32'h100);
    tick(); stall_i = 1'b0; redirect_i = 1'b0;
    @(negedge clk);
    check("rs_valid", id_valid_o, 0);
    check("rs_inst", id_inst_o, NOP);
    check("rs_pchold", id_pc_o, 32'h100);
    check("rs_addr", imem_addr_o, 32'h200);
    tick(); @(negedge clk); check("rs_addr2", imem_addr_o, 32'h204);

    // c15: redirect to the top of the address space, then sequential wrap
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; restart_stream(32'hFFFF_FFFC);
    @(negedge clk); check("c15_pc", id_pc_o, 32'h200);
    tick(); redirect_i = 1'b0;
    @(negedge clk); check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    tick(); mem_lat = 3;
    @(negedge clk); check("wrap_addr1", imem_addr_o, 32'h0);
    tick(); @(negedge clk);
    check("wrap_pc", id_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc_plus4_o, 32'h0);
    check("wrap_req", imem_req_o, 0);

    // Reset mid-WAIT; the stale response lands while reset is still held
    #1; rst_n = 1'b0; #1;
    check("ar_valid", id_valid_o, 0);
    check("ar_pc", id_pc_o, 0);
    check("ar_pc4", id_pc_plus4_o, 0);
    check("ar_inst", id_inst_o, NOP);
    check("ar_req", imem_req_o, 0);
    tick(); tick(); mem_lat = 1;
    @(negedge clk); check("ar_req2", imem_req_o, 0);
    tick(); rst_n = 1'b1; restart_stream(RST_PC);
    @(negedge clk);
    check("ar_addr", imem_addr_o, RST_PC);
    check("ar_req3", imem_req_o, 1);
    check("ar_valid2", id_valid_o, 0);

    // Randomized stalls, redirects and memory latency
    rand_lat = 1'b1;
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      tick();
      stall_i    = ($urandom_range(0, 99) < 30);
      redirect_i = ($urandom_range(0, 99) < 5);
      if (redirect_i) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
        redirect_pc_i = tgt;
        restart_stream(tgt & ~32'h3);
      end
    end
    tick(); stall_i = 1'b0; redirect_i = 1'b0;
    repeat (10) tick();
    n_tests++;
    if (consumed - base < 300) begin
      n_fail++;
      $display("FAIL progress: got %0d expected >= 300 instructions", consumed - base);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
